// File: rtl/seq_mult_param_if.sv
// Handshake/bus bundle for seq_mult_param: start/operands from the controller,
// status, product and iteration count back from the multiplier.
//   master : controller side (drives start, a, b, signed_mode)
//   slave  : multiplier side (drives ready, busy, done, product, iter_cnt)
interface seq_mult_param_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [CNT_W-1:0]     iter_cnt;

    modport master (
        output start, a, b, signed_mode,
        input  ready, busy, done, product, iter_cnt
    );

    modport slave (
        input  start, a, b, signed_mode,
        output ready, busy, done, product, iter_cnt
    );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed/unsigned.
// Ports: clk, reset (sync, active-high), bus (seq_mult_param_if.slave):
//   start/a/b/signed_mode in; ready/busy/done/product/iter_cnt out.
// Optional macro SEQ_MULT_EARLY_EXIT_EN: finish as soon as the remaining
//   multiplier bits are all zero (1..WIDTH cycles instead of fixed WIDTH).
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    seq_mult_param_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   ma_q, ma_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PW-1:0]      addend;
    logic [PW-1:0]      acc_nx;
    logic [WIDTH-1:0]   mb_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               last;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Magnitudes stay WIDTH-bit unsigned: |-2^(WIDTH-1)| still fits.
    always_comb begin
        a_mag = bus.a;
        b_mag = bus.b;
        if (bus.signed_mode && bus.a[WIDTH-1]) a_mag = ~bus.a + 1'b1;
        if (bus.signed_mode && bus.b[WIDTH-1]) b_mag = ~bus.b + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;

        addend = mb_q[0] ? (PW'(ma_q) << cnt_q) : '0;
        acc_nx = acc_q + addend;
        mb_nx  = mb_q >> 1;
        cnt_nx = cnt_q + 1'b1;
        last   = (cnt_nx == CNT_W'(WIDTH));
`ifdef SEQ_MULT_EARLY_EXIT_EN
        last   = last || (mb_nx == '0);
`else
`endif

        unique case (state_q)
            S_RUN: begin
                acc_d = acc_nx;
                mb_d  = mb_nx;
                cnt_d = cnt_nx;
                if (last) begin
                    state_d = S_DONE;
                    prod_d  = neg_q ? (-acc_nx) : acc_nx;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
                state_d = S_IDLE;
                if (bus.start) begin
                    state_d = S_RUN;
                    ma_d    = a_mag;
                    mb_d    = b_mag;
                    neg_d   = bus.signed_mode &
                              (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.ready    = (state_q != S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.product  = prod_q;
    assign bus.iter_cnt = cnt_q;
endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param (WIDTH=8): random and directed
// operations checked against an arithmetic reference model.
module tb_seq_mult_param;
    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] p;
        int             it;
        int             cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    bit   mon_en;
    exp_t q[$];
    logic [2*W-1:0] hold_p;
    int   hold_it;

    seq_mult_param_if #(.WIDTH(W)) bus ();

    seq_mult_param #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] av,
                                               input logic [W-1:0] bv,
                                               input logic sm);
        longint x, y, r;
        x = sm ? longint'($signed(av)) : longint'(av);
        y = sm ? longint'($signed(bv)) : longint'(bv);
        r = x * y;
        return r[2*W-1:0];
    endfunction

    function automatic int lat_of(input logic [W-1:0] bv, input logic sm);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        int mag, n;
        mag = (sm && bv[W-1]) ? (256 - int'(bv)) : int'(bv);
        n = 0;
        while (mag != 0) begin
            n++;
            mag = mag / 2;
        end
        return (n == 0) ? 1 : n;
`else
        return W;
`endif
    endfunction

    // Monitor: pops one expectation per done pulse; otherwise checks holds.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ready_not_busy", bus.ready, !bus.busy);
            chk("done_busy_excl", bus.done && bus.busy, 0);
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("product", bus.product, e.p);
                    chk("iter_cnt", bus.iter_cnt, e.it);
                    chk("latency", cyc, e.cyc);
                    hold_p  = e.p;
                    hold_it = e.it;
                end
            end else begin
                chk("product_hold", bus.product, hold_p);
                if (bus.ready) chk("iter_hold", bus.iter_cnt, hold_it);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("ready_timeout", 0, 1);
    endtask

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sm, input bit push);
        int lat;
        bus.start       = 1'b1;
        bus.a           = av;
        bus.b           = bv;
        bus.signed_mode = sm;
        lat = lat_of(bv, sm);
        if (push) q.push_back('{ref_mul(av, bv, sm), lat, cyc + 1 + lat});
    endtask

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic sm);
        wait_ready();
        drive(av, bv, sm, 1'b1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // start held high through RUN with scrambled operands, then a
    // back-to-back second operation issued in the done cycle.
    task automatic hold_pair(input logic [W-1:0] a1, input logic [W-1:0] b1,
                             input logic s1, input logic [W-1:0] a2,
                             input logic [W-1:0] b2, input logic s2);
        int n;
        wait_ready();
        drive(a1, b1, s1, 1'b1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.ready) begin
                bus.a           = W'($urandom);
                bus.b           = W'($urandom);
                bus.signed_mode = 1'($urandom);
            end
        end while (!bus.ready && n < 100);
        if (n >= 100) chk("hold_timeout", 0, 1);
        drive(a2, b2, s2, 1'b1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        cyc             = 0;
        checks          = 0;
        failures        = 0;
        mon_en          = 1'b0;
        hold_p          = '0;
        hold_it         = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_product", bus.product, 0);
        chk("rst_iter", bus.iter_cnt, 0);
        mon_en = 1'b1;

        op(8'd255, 8'd255, 1'b0);
        op(8'h80, 8'h80, 1'b1);
        op(8'hFD, 8'd5, 1'b1);
        op(8'd127, 8'hFF, 1'b1);
        hold_pair(8'd11, 8'd13, 1'b0, 8'hF0, 8'd9, 1'b1);
        drain();

        // Abort mid-run: no done pulse, all outputs back to reset values.
        wait_ready();
        drive(8'd7, 8'd9, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        hold_p  = '0;
        hold_it = 0;
        chk("abort_ready", bus.ready, 1);
        chk("abort_product", bus.product, 0);
        chk("abort_iter", bus.iter_cnt, 0);
        chk("abort_done", bus.done, 0);
        op(8'd7, 8'd9, 1'b0);

        op(8'd6, 8'd7, 1'b0);
        op(8'd3, 8'd3, 1'b0);
        op(8'd200, 8'd1, 1'b0);
        op(8'd200, 8'd0, 1'b0);
        op(8'd200, 8'h80, 1'b0);
        op(8'h80, 8'h7F, 1'b1);
        op(8'h01, 8'h80, 1'b1);
        drain();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                hold_pair(W'($urandom), W'($urandom), 1'($urandom),
                          W'($urandom), W'($urandom), 1'($urandom));
            end else begin
                op(W'($urandom), W'($urandom), 1'($urandom));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
